// File: rtl/mma_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mma_wb_ctrl_pkg
// Brief    : Shared FSM encodings and defaults for the MMA writeback path.
//            The encodings match the ones used by the retire tracker.
// Revision : 1.0 - initial release
// ============================================================================
package mma_wb_ctrl_pkg;

  // Writeback controller states (2-bit encoding shared with the retire tracker)
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_wb   = 2'd2;

  // Default watchdog depth in CALC cycles
  localparam int c_timeout_default = 1024;

  // Watchdog counter width: enough to hold TIMEOUT, never narrower than 1 bit
  function automatic int wdog_cnt_w(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : mma_wb_ctrl_pkg
`default_nettype wire

// File: rtl/mma_wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mma_wb_watchdog
// Brief    : Saturating CALC-cycle counter. Raises fire while enabled and the
//            count has reached TIMEOUT-1. TIMEOUT = 0 disables it entirely.
// Revision : 1.0 - initial release
// ============================================================================
module mma_wb_watchdog
  import mma_wb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic fire
);

  localparam int c_cnt_w = wdog_cnt_w(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_wdog_off
      assign fire = 1'b0;
    end else begin : g_wdog_on
      localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
      localparam logic [c_cnt_w-1:0] c_fire_at = c_cnt_w'(TIMEOUT - 1);
      localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

      logic [c_cnt_w-1:0] r_cnt;

      // Count enabled cycles; clear wins, and the count sticks at its maximum
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (clear) begin
          r_cnt <= '0;
        end else if (enable && (r_cnt != c_cnt_max)) begin
          r_cnt <= r_cnt + c_one;
        end
      end

      assign fire = enable && (r_cnt == c_fire_at);
    end
  endgenerate

endmodule : mma_wb_watchdog
`default_nettype wire

// File: rtl/mma_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mma_wb_ctrl
// Brief    : MMA writeback controller. Tracks one outstanding instruction,
//            captures rd at start and result at done, and presents a stable
//            writeback until accepted. A watchdog forces an error writeback.
// Revision : 1.0 - initial release
// ============================================================================
module mma_wb_ctrl
  import mma_wb_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = c_timeout_default
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calc_start,
  input  logic [RD_W-1:0]   calc_rd,
  input  logic              calc_done,
  input  logic [DATA_W-1:0] calc_result,
  input  logic              calc_err,
  output logic              mma_wb_valid,
  input  logic              mma_wb_ready,
  output logic [DATA_W-1:0] mma_wb_data,
  output logic [RD_W-1:0]   mma_wb_rd,
  output logic              mma_wb_err,
  output logic              busy,
  output logic              timeout,
  output logic              proto_err
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic              r_valid;
  logic              r_busy;
  logic [DATA_W-1:0] r_data;
  logic [RD_W-1:0]   r_rd;
  logic              r_err;
  logic              r_timeout;
  logic              r_proto;

  logic [DATA_W-1:0] w_data_nxt;
  logic [RD_W-1:0]   w_rd_nxt;
  logic              w_err_nxt;
  logic              w_timeout_nxt;
  logic              w_proto_nxt;

  logic              w_in_idle;
  logic              w_in_calc;
  logic              w_in_wb;
  logic              w_hs;
  logic              w_take_start;
  logic              w_fire;

  assign w_in_idle    = (r_state == c_st_idle);
  assign w_in_calc    = (r_state == c_st_calc);
  assign w_in_wb      = (r_state == c_st_wb);
  // Valid is high exactly in WB, so the handshake only needs ready there
  assign w_hs         = w_in_wb && mma_wb_ready;
  // A start is accepted from IDLE, or from WB in the same cycle as the handshake
  assign w_take_start = calc_start && (w_in_idle || w_hs);

  mma_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_take_start),
    .enable (w_in_calc),
    .fire   (w_fire)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: done or watchdog ends CALC; handshake ends WB (or re-enters CALC)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (calc_start) begin
          w_state_nxt = c_st_calc;
        end
      end
      c_st_calc: begin
        if (calc_done || w_fire) begin
          w_state_nxt = c_st_wb;
        end
      end
      c_st_wb: begin
        if (mma_wb_ready) begin
          w_state_nxt = calc_start ? c_st_calc : c_st_idle;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Output next-values: captures, forced error writeback and sticky flags
  always_comb begin
    w_data_nxt    = r_data;
    w_rd_nxt      = r_rd;
    w_err_nxt     = r_err;
    w_timeout_nxt = r_timeout;
    w_proto_nxt   = r_proto;

    if (w_take_start) begin
      w_rd_nxt = calc_rd;
    end

    if (w_in_calc) begin
      if (calc_done) begin
        // A real result beats a watchdog expiring in the same cycle
        w_data_nxt = calc_result;
        w_err_nxt  = calc_err;
      end else if (w_fire) begin
        w_data_nxt    = '0;
        w_err_nxt     = 1'b1;
        w_timeout_nxt = 1'b1;
      end
      if (calc_start) begin
        w_proto_nxt = 1'b1;
      end
    end

    // A done outside CALC has nothing to attach to
    if ((w_in_idle || w_in_wb) && calc_done) begin
      w_proto_nxt = 1'b1;
    end

    // A start while the writeback is still pending would lose an instruction
    if (w_in_wb && calc_start && !mma_wb_ready) begin
      w_proto_nxt = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_data    <= '0;
      r_rd      <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_proto   <= 1'b0;
    end else begin
      r_valid   <= (w_state_nxt == c_st_wb);
      r_busy    <= (w_state_nxt != c_st_idle);
      r_data    <= w_data_nxt;
      r_rd      <= w_rd_nxt;
      r_err     <= w_err_nxt;
      r_timeout <= w_timeout_nxt;
      r_proto   <= w_proto_nxt;
    end
  end

  assign mma_wb_valid = r_valid;
  assign busy         = r_busy;
  assign mma_wb_data  = r_data;
  assign mma_wb_rd    = r_rd;
  assign mma_wb_err   = r_err;
  assign timeout      = r_timeout;
  assign proto_err    = r_proto;

endmodule : mma_wb_ctrl
`default_nettype wire

// File: tb/tb_mma_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mma_wb_ctrl
// Brief    : Self-checking bench for mma_wb_ctrl. A transaction-level model
//            predicts every output each cycle; directed scenarios add literal
//            expectations at the key cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mma_wb_ctrl;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          calc_start = 1'b0;
  logic [RW-1:0] calc_rd = '0;
  logic          calc_done = 1'b0;
  logic [DW-1:0] calc_result = '0;
  logic          calc_err = 1'b0;
  logic          mma_wb_valid;
  logic          mma_wb_ready = 1'b0;
  logic [DW-1:0] mma_wb_data;
  logic [RW-1:0] mma_wb_rd;
  logic          mma_wb_err;
  logic          busy;
  logic          timeout;
  logic          proto_err;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  mma_wb_ctrl #(
    .DATA_W  (DW),
    .RD_W    (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .calc_start   (calc_start),
    .calc_rd      (calc_rd),
    .calc_done    (calc_done),
    .calc_result  (calc_result),
    .calc_err     (calc_err),
    .mma_wb_valid (mma_wb_valid),
    .mma_wb_ready (mma_wb_ready),
    .mma_wb_data  (mma_wb_data),
    .mma_wb_rd    (mma_wb_rd),
    .mma_wb_err   (mma_wb_err),
    .busy         (busy),
    .timeout      (timeout),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = nothing outstanding, 1 = waiting on the core,
  // 2 = result presented. m_age counts cycles spent waiting on the core.
  int            m_phase;
  int            m_age;
  logic [DW-1:0] e_data;
  logic [RW-1:0] e_rd;
  logic          e_err;
  logic          e_to;
  logic          e_pe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_age   <= 0;
      e_data  <= '0;
      e_rd    <= '0;
      e_err   <= 1'b0;
      e_to    <= 1'b0;
      e_pe    <= 1'b0;
    end else if (m_phase == 0) begin
      if (calc_done) e_pe <= 1'b1;
      if (calc_start) begin
        e_rd    <= calc_rd;
        m_age   <= 0;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (calc_start) e_pe <= 1'b1;
      if (calc_done) begin
        e_data  <= calc_result;
        e_err   <= calc_err;
        m_phase <= 2;
      end else if (m_age == TO - 1) begin
        e_data  <= '0;
        e_err   <= 1'b1;
        e_to    <= 1'b1;
        m_phase <= 2;
      end else begin
        m_age <= m_age + 1;
      end
    end else begin
      if (calc_done) e_pe <= 1'b1;
      if (mma_wb_ready) begin
        if (calc_start) begin
          e_rd    <= calc_rd;
          m_age   <= 0;
          m_phase <= 1;
        end else begin
          m_phase <= 0;
        end
      end else if (calc_start) begin
        e_pe <= 1'b1;
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      n_chk++;
      if ({mma_wb_valid, busy, mma_wb_data, mma_wb_rd, mma_wb_err, timeout, proto_err} ===
          {(m_phase == 2), (m_phase != 0), e_data, e_rd, e_err, e_to, e_pe}) begin
        n_pass++;
      end else begin
        $display("FAIL model_cmp t=%0t got v=%b b=%b d=%h rd=%0d e=%b to=%b pe=%b exp v=%b b=%b d=%h rd=%0d e=%b to=%b pe=%b",
                 $time, mma_wb_valid, busy, mma_wb_data, mma_wb_rd, mma_wb_err, timeout, proto_err,
                 (m_phase == 2), (m_phase != 0), e_data, e_rd, e_err, e_to, e_pe);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL sim_time_limit: bench did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    cyc();
    chk_on = 1'b1;
    cyc();
    chk("reset_outs", {25'd0, mma_wb_valid, busy, mma_wb_err, timeout, proto_err, 2'b00}, 32'd0);
    chk("reset_data", mma_wb_data, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Basic: start at cycle 0, done at cycle 3, ready high throughout
    mma_wb_ready = 1'b1;
    calc_start = 1'b1; calc_rd = 5'd5;
    cyc();
    calc_start = 1'b0;
    chk("basic_busy_c1", busy, 1);
    cyc(); cyc();
    chk("basic_valid_c3", mma_wb_valid, 0);
    calc_done = 1'b1; calc_result = 32'hDEADBEEF;
    cyc();
    calc_done = 1'b0;
    chk("basic_valid_c4", mma_wb_valid, 1);
    chk("basic_data_c4", mma_wb_data, 32'hDEADBEEF);
    chk("basic_rd_c4", mma_wb_rd, 5);
    chk("basic_err_c4", mma_wb_err, 0);
    cyc();
    chk("basic_idle_c5", {mma_wb_valid, busy}, 0);

    // Backpressure with minimum latency and an error result
    mma_wb_ready = 1'b0;
    calc_start = 1'b1; calc_rd = 5'd3;
    cyc();
    calc_start = 1'b0;
    chk("bp_valid_c1", mma_wb_valid, 0);
    calc_done = 1'b1; calc_result = 32'h12345678; calc_err = 1'b1;
    cyc();
    calc_done = 1'b0; calc_err = 1'b0;
    chk("bp_valid_c2", mma_wb_valid, 1);
    repeat (10) cyc();
    chk("bp_hold_valid", mma_wb_valid, 1);
    chk("bp_hold_data", mma_wb_data, 32'h12345678);
    chk("bp_hold_rd", mma_wb_rd, 3);
    chk("bp_hold_err", mma_wb_err, 1);
    mma_wb_ready = 1'b1;
    cyc();
    mma_wb_ready = 1'b0;
    chk("bp_after_hs", {mma_wb_valid, busy}, 0);

    // Back-to-back issue on the handshake cycle
    calc_start = 1'b1; calc_rd = 5'd2;
    cyc();
    calc_start = 1'b0;
    calc_done = 1'b1; calc_result = 32'hCAFE0000;
    cyc();
    calc_done = 1'b0;
    chk("b2b_first_rd", mma_wb_rd, 2);
    mma_wb_ready = 1'b1; calc_start = 1'b1; calc_rd = 5'd7;
    cyc();
    mma_wb_ready = 1'b0; calc_start = 1'b0;
    chk("b2b_busy_valid", {mma_wb_valid, busy}, 32'b01);
    chk("b2b_rd_new", mma_wb_rd, 7);
    chk("b2b_data_held", mma_wb_data, 32'hCAFE0000);
    cyc();
    calc_done = 1'b1; calc_result = 32'h1;
    cyc();
    calc_done = 1'b0;
    chk("b2b_wb", {mma_wb_valid, 26'd0, mma_wb_rd}, {1'b1, 26'd0, 5'd7});
    chk("b2b_data", mma_wb_data, 32'h1);
    mma_wb_ready = 1'b1;
    cyc();
    mma_wb_ready = 1'b0;
    chk("b2b_no_proto", proto_err, 0);

    // Done lands on the same cycle the watchdog would fire
    calc_start = 1'b1; calc_rd = 5'd11;
    cyc();
    calc_start = 1'b0;
    repeat (7) cyc();
    calc_done = 1'b1; calc_result = 32'hA5A5A5A5;
    cyc();
    calc_done = 1'b0;
    chk("race_valid_c9", mma_wb_valid, 1);
    chk("race_data", mma_wb_data, 32'hA5A5A5A5);
    chk("race_err_to", {mma_wb_err, timeout}, 0);
    mma_wb_ready = 1'b1;
    cyc();
    mma_wb_ready = 1'b0;

    // Watchdog fires with no done
    calc_start = 1'b1; calc_rd = 5'd12;
    cyc();
    calc_start = 1'b0;
    repeat (7) cyc();
    chk("wdog_valid_c8", mma_wb_valid, 0);
    cyc();
    chk("wdog_valid_c9", mma_wb_valid, 1);
    chk("wdog_data", mma_wb_data, 32'd0);
    chk("wdog_err_to", {mma_wb_err, timeout}, 32'b11);
    chk("wdog_rd", mma_wb_rd, 12);
    mma_wb_ready = 1'b1;
    cyc();
    mma_wb_ready = 1'b0;
    chk("wdog_to_sticky", {mma_wb_valid, timeout}, 32'b01);

    // Protocol errors
    chk("pe_clear", proto_err, 0);
    calc_done = 1'b1;
    cyc();
    calc_done = 1'b0;
    chk("pe_done_idle", {busy, proto_err}, 32'b01);
    calc_start = 1'b1; calc_rd = 5'd9;
    cyc();
    calc_rd = 5'd4;
    cyc();
    calc_start = 1'b0;
    chk("pe_start_calc_rd", mma_wb_rd, 9);
    chk("pe_start_calc_st", {mma_wb_valid, busy}, 32'b01);
    calc_done = 1'b1; calc_result = 32'h55;
    cyc();
    calc_done = 1'b0;
    chk("pe_wb_data", mma_wb_data, 32'h55);
    calc_start = 1'b1; calc_rd = 5'd1;
    cyc();
    calc_start = 1'b0;
    chk("pe_start_wb", {mma_wb_valid, 26'd0, mma_wb_rd}, {1'b1, 26'd0, 5'd9});
    mma_wb_ready = 1'b1;
    cyc();
    mma_wb_ready = 1'b0;
    chk("pe_sticky", {busy, proto_err}, 32'b01);

    // Start and done together in IDLE: start taken, done flagged
    calc_start = 1'b1; calc_done = 1'b1; calc_rd = 5'd6; calc_result = 32'hFFFF;
    cyc();
    calc_start = 1'b0; calc_done = 1'b0;
    chk("sd_idle", {mma_wb_valid, busy, 25'd0, mma_wb_rd}, {2'b01, 25'd0, 5'd6});
    calc_done = 1'b1; calc_result = 32'h77;
    cyc();
    calc_done = 1'b0;
    chk("sd_wb_data", mma_wb_data, 32'h77);

    // Asynchronous reset while presenting a writeback
    chk("rst_pre_valid", mma_wb_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {25'd0, mma_wb_valid, busy, mma_wb_err, timeout, proto_err, 2'b00}, 32'd0);
    chk("rst_async_data", {mma_wb_data[26:0], mma_wb_rd}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    calc_start = 1'b1; calc_rd = 5'd13;
    cyc();
    calc_start = 1'b0;
    chk("rst_restart", {busy, 26'd0, mma_wb_rd}, {1'b1, 26'd0, 5'd13});
    calc_done = 1'b1; calc_result = 32'h0BADF00D;
    cyc();
    calc_done = 1'b0;
    chk("rst_restart_data", mma_wb_data, 32'h0BADF00D);
    mma_wb_ready = 1'b1;
    cyc();
    mma_wb_ready = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_mma_wb_ctrl
`default_nettype wire
